gb_oam_dma: RTL and testbench
=============================

GB_OAM_DMA -- requirements
Module: gb_oam_dma

Interface
REQ-001 Parameter CYCLE_CLKS, default 4: clk periods per machine cycle; SHALL be >= 2.
REQ-002 Parameter LENGTH, default 160: bytes per transfer; SHALL be fixed at 160 for DMG use.
REQ-003 clk  in  1  system clock; one clock; all state SHALL change on its rising edge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 reg_write  in  1  CPU write strobe, already decoded for address FF46.
REQ-006 din  in  8  CPU write data (source page high byte).
REQ-007 dout  out  8  register readback: last value written to FF46.
REQ-008 active  out  1  transfer in progress; the CPU map SHALL block non-HRAM accesses while it is high.
REQ-009 src_adr  out  16  source address driven into the DMA-side memory map.
REQ-010 src_read  out  1  source read strobe.
REQ-011 src_din  in  8  source byte returned by the memory map.
REQ-012 oam_adr  out  8  OAM byte index, range 00-9F.
REQ-013 oam_dout  out  8  byte to write into OAM.
REQ-014 oam_write  out  1  OAM write strobe, one clk wide.

Function
REQ-015 States SHALL be IDLE, START and XFER; a phase counter SHALL run 0..CYCLE_CLKS-1 in START and XFER.
REQ-016 reg_write sampled high SHALL load the page register from din, enter START with phase 0 and byte index 0, and raise active on the same edge.
REQ-017 START SHALL last exactly CYCLE_CLKS clocks (one M-cycle setup delay) with no src_read and no oam_write, then enter XFER.
REQ-018 In XFER, src_adr SHALL equal {page_eff, index} for the whole M-cycle, and src_read SHALL be high at phase 0.
REQ-019 src_din SHALL be captured at phase CYCLE_CLKS-1.
REQ-020 oam_write SHALL pulse for one clk at phase CYCLE_CLKS-1, with oam_adr = index and oam_dout = src_din in that same clk.
REQ-021 After the write, the index SHALL increment; the write at index LENGTH-1 (9F) SHALL return the block to IDLE and drop active on the same edge.
REQ-022 Total active time SHALL be (LENGTH+1)*CYCLE_CLKS clocks: 644 with the defaults.
REQ-023 page_eff SHALL equal page for 00-DF; pages E0-FF SHALL map to page-0x20 (echo RAM mirrors C000-DFFF).
REQ-024 A reg_write while active (restart) SHALL reload the page, restart START from index 0, and abort the pending write of the current M-cycle; no partial-index write SHALL occur.
REQ-025 A reg_write coinciding with the final write SHALL take priority: the final write is dropped, START is entered, and active stays high.
REQ-026 dout SHALL always reflect the page register, independent of state.
REQ-027 Outside XFER, oam_write and src_read SHALL be 0; src_adr and oam_adr SHALL hold their last values.
REQ-028 Index arithmetic SHALL be 8-bit and never exceed 9F; src_adr low byte SHALL equal the index.

Reset
REQ-029 n_reset low SHALL asynchronously force state IDLE, phase 0, index 0, page register 00, and active 0.
REQ-030 n_reset low SHALL also asynchronously force oam_write 0, src_read 0, src_adr 0000 and oam_adr 00.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no further OAM writes; OAM contents are left partially updated.
REQ-032 Release of n_reset SHALL take effect on the next clk edge; the top level SHALL synchronise deassertion.

Structure
REQ-033 Package gb_pkg SHALL hold OAM_DMA_REG_ADR (FF46), OAM_BASE (FE00), OAM_DMA_LEN (160), ECHO_OFFSET (20) and the state enumeration.
REQ-034 No sub-module SHALL be used; the phase counter and index counter SHALL be inline.
REQ-035 The top level SHALL connect src_adr/src_read to the DMA-side gb_memmap instance, and the OAM port SHALL be muxed by active.

Verification
REQ-036 reg_write with din=C0, ROM model returning low byte xor 5A -> oam_write pulses 160 times at 4-clk spacing, first one 8 clks after the write, OAM[00..9F] = 5A..C5, active high for 644 clks.
REQ-037 din=E1 -> src_adr runs C100..C19F; E100 never appears.
REQ-038 Restart with din=D0 after 50 bytes -> index returns to 0, no write at index 50, 160 further writes from D000, total active = 51*4 + 644 clks.
REQ-039 reg_write on the clk of the index-9F write -> that write is dropped, active never falls, new transfer completes.
REQ-040 n_reset pulsed low for 1 clk at byte 100 -> outputs zero immediately, no write after reset, dout reads 00.
REQ-041 CYCLE_CLKS=2 build, din=80 -> 322 active clks, 160 correct writes.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared Game Boy definitions used by the OAM DMA engine: register and
// memory-map constants, the DMA state encoding and the echo-RAM page fold.
package gb_pkg;

    localparam logic [15:0] OAM_DMA_REG_ADR = 16'hFF46;
    localparam logic [15:0] OAM_BASE        = 16'hFE00;
    localparam int unsigned OAM_DMA_LEN     = 160;
    localparam logic [7:0]  ECHO_OFFSET     = 8'h20;
    localparam logic [7:0]  ECHO_FIRST_PAGE = 8'hE0;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_e;

    // Pages E0-FF alias C000-DFFF (echo RAM), so the DMA fetches from the real RAM page.
    function automatic logic [7:0] dma_page_eff(input logic [7:0] page);
        logic [7:0] eff;
        if (page >= ECHO_FIRST_PAGE) begin
            eff = page - ECHO_OFFSET;
        end else begin
            eff = page;
        end
        return eff;
    endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// Game Boy OAM DMA engine. A write to FF46 copies LENGTH bytes from page
// {din,00} into OAM, one byte per machine cycle, after a one machine-cycle
// setup delay. The source address/read strobe feed the DMA side of the
// memory map; the OAM write port is driven only while a transfer is active.
module gb_oam_dma
    import gb_pkg::*;
#(
    parameter int unsigned CYCLE_CLKS = 4,          // clk periods per machine cycle, >= 2
    parameter int unsigned LENGTH     = OAM_DMA_LEN // bytes per transfer
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        reg_write,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        active,
    output logic [15:0] src_adr,
    output logic        src_read,
    input  logic [7:0]  src_din,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_dout,
    output logic        oam_write
);

    localparam int unsigned   PW       = (CYCLE_CLKS > 2) ? $clog2(CYCLE_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLE_CLKS - 1);
    localparam logic [PW-1:0] PH_PRE   = PW'(CYCLE_CLKS - 2);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [7:0]    IDX_LAST = 8'(LENGTH - 1);

    logic          rst_sync_q;
    dma_state_e    state_q;
    logic [PW-1:0] phase_q;
    logic [7:0]    index_q;
    logic [7:0]    page_q;
    logic          active_q;
    logic [15:0]   src_adr_q;
    logic          src_read_q;
    logic [7:0]    oam_adr_q;
    logic          oam_write_q;

    logic [7:0]    page_eff_s;
    logic [7:0]    index_next_s;

    assign page_eff_s   = dma_page_eff(page_q);
    assign index_next_s = index_q + 8'd1;

    // Reset synchroniser: assertion reaches the state flops at once, release on the next clk edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    // Transfer sequencer: page register, phase/index counters and all registered outputs
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= DMA_IDLE;
            phase_q     <= '0;
            index_q     <= 8'h00;
            page_q      <= 8'h00;
            active_q    <= 1'b0;
            src_adr_q   <= 16'h0000;
            src_read_q  <= 1'b0;
            oam_adr_q   <= 8'h00;
            oam_write_q <= 1'b0;
        end else if (reg_write) begin
            // A register write always (re)starts from index 0; any pending byte is abandoned.
            page_q      <= din;
            state_q     <= DMA_START;
            phase_q     <= '0;
            index_q     <= 8'h00;
            active_q    <= 1'b1;
            src_read_q  <= 1'b0;
            oam_write_q <= 1'b0;
        end else begin
            case (state_q)
                DMA_START: begin
                    oam_write_q <= 1'b0;
                    if (phase_q == PH_LAST) begin
                        state_q    <= DMA_XFER;
                        phase_q    <= '0;
                        src_adr_q  <= {page_eff_s, index_q};
                        oam_adr_q  <= index_q;
                        src_read_q <= 1'b1;
                    end else begin
                        phase_q    <= phase_q + PH_ONE;
                        src_read_q <= 1'b0;
                    end
                end
                DMA_XFER: begin
                    if (phase_q == PH_LAST) begin
                        // The OAM write has just completed on this edge.
                        oam_write_q <= 1'b0;
                        phase_q     <= '0;
                        if (index_q == IDX_LAST) begin
                            state_q    <= DMA_IDLE;
                            active_q   <= 1'b0;
                            index_q    <= 8'h00;
                            src_read_q <= 1'b0;
                        end else begin
                            index_q    <= index_next_s;
                            src_adr_q  <= {page_eff_s, index_next_s};
                            oam_adr_q  <= index_next_s;
                            src_read_q <= 1'b1;
                        end
                    end else begin
                        phase_q     <= phase_q + PH_ONE;
                        src_read_q  <= 1'b0;
                        // Strobe is high during the last clk of the machine cycle.
                        oam_write_q <= (phase_q == PH_PRE);
                    end
                end
                default: begin
                    // IDLE, and recovery path for any unused encoding.
                    state_q     <= DMA_IDLE;
                    phase_q     <= '0;
                    active_q    <= 1'b0;
                    src_read_q  <= 1'b0;
                    oam_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout     = page_q;
    assign active   = active_q;
    assign src_adr  = src_adr_q;
    assign src_read = src_read_q;
    assign oam_adr  = oam_adr_q;
    // A register write landing on the write clk wins: the in-flight OAM write is suppressed.
    assign oam_write = oam_write_q & ~reg_write;
    // OAM data port only carries DMA data while a transfer owns it.
    assign oam_dout  = active_q ? src_din : 8'h00;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Directed/randomised bench for gb_oam_dma: a CYCLE_CLKS=4 instance for the
// main scenarios and a CYCLE_CLKS=2 instance, each with a reference model.
module tb_gb_oam_dma;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory content: a known function of the full address.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC0;
    endfunction

    function automatic logic [7:0] page_map(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    // ---------------- instance A (4 clks per M-cycle) ----------------
    logic        rw_a = 1'b0;
    logic [7:0]  din_a = 8'h00;
    logic [7:0]  dout_a, sdin_a, oadr_a, odout_a;
    logic [15:0] sadr_a;
    logic        act_a, srd_a, ow_a;
    assign sdin_a = rom(sadr_a);

    gb_oam_dma #(.CYCLE_CLKS(4), .LENGTH(160)) u_dut_a (
        .clk(clk), .n_reset(n_reset), .reg_write(rw_a), .din(din_a), .dout(dout_a),
        .active(act_a), .src_adr(sadr_a), .src_read(srd_a), .src_din(sdin_a),
        .oam_adr(oadr_a), .oam_dout(odout_a), .oam_write(ow_a)
    );

    // ---------------- instance B (2 clks per M-cycle) ----------------
    logic        rw_b = 1'b0;
    logic [7:0]  din_b = 8'h00;
    logic [7:0]  dout_b, sdin_b, oadr_b, odout_b;
    logic [15:0] sadr_b;
    logic        act_b, srd_b, ow_b;
    assign sdin_b = rom(sadr_b);

    gb_oam_dma #(.CYCLE_CLKS(2), .LENGTH(160)) u_dut_b (
        .clk(clk), .n_reset(n_reset), .reg_write(rw_b), .din(din_b), .dout(dout_b),
        .active(act_b), .src_adr(sadr_b), .src_read(srd_b), .src_din(sdin_b),
        .oam_adr(oadr_b), .oam_dout(odout_b), .oam_write(ow_b)
    );

    // Model state: effective page, time of the load edge, next expected byte index.
    logic [7:0] m_page_a, m_page_b;
    int m_t0_a = 0, m_t0_b = 0, m_idx_a = 0, m_idx_b = 0;
    int w_cnt_a = 0, act_cnt_a = 0, err_a = 0, echo_a = 0;
    int w_cnt_b = 0, act_cnt_b = 0, err_b = 0;
    logic [7:0] oam_a [0:159];
    logic [7:0] oam_b [0:159];

    // Monitor A: byte i is read at M-cycle i+1 and written in the last clk of that M-cycle.
    always @(negedge clk) begin
        if (act_a) act_cnt_a++;
        if ((ow_a || srd_a) && !act_a) err_a++;
        if (srd_a) begin
            if (sadr_a !== {m_page_a, 8'(m_idx_a)} || (cyc - m_t0_a) != 4 * (m_idx_a + 1)) err_a++;
            if (sadr_a[15:13] == 3'b111) echo_a++;
        end
        if (ow_a) begin
            if (oadr_a !== 8'(m_idx_a) || odout_a !== rom({m_page_a, oadr_a})
                || (cyc - m_t0_a) != 4 * (m_idx_a + 2) - 1) err_a++;
            if (oadr_a < 8'd160) oam_a[oadr_a] = odout_a;
            else err_a++;
            w_cnt_a++;
            m_idx_a++;
        end
    end

    // Monitor B: same rules with 2 clks per M-cycle.
    always @(negedge clk) begin
        if (act_b) act_cnt_b++;
        if ((ow_b || srd_b) && !act_b) err_b++;
        if (srd_b) begin
            if (sadr_b !== {m_page_b, 8'(m_idx_b)} || (cyc - m_t0_b) != 2 * (m_idx_b + 1)) err_b++;
        end
        if (ow_b) begin
            if (oadr_b !== 8'(m_idx_b) || odout_b !== rom({m_page_b, oadr_b})
                || (cyc - m_t0_b) != 2 * (m_idx_b + 2) - 1) err_b++;
            if (oadr_b < 8'd160) oam_b[oadr_b] = odout_b;
            else err_b++;
            w_cnt_b++;
            m_idx_b++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        w_cnt_a = 0; act_cnt_a = 0; err_a = 0; echo_a = 0;
        for (int i = 0; i < 160; i++) oam_a[i] = 8'hxx;
    endtask

    task automatic kick_a(input logic [7:0] d);
        @(posedge clk); #2;
        rw_a = 1'b1; din_a = d;
        @(posedge clk); #1;
        rw_a = 1'b0;
        m_page_a = page_map(d); m_t0_a = cyc; m_idx_a = 0;
    endtask

    task automatic kick_b(input logic [7:0] d);
        @(posedge clk); #2;
        rw_b = 1'b1; din_b = d;
        @(posedge clk); #1;
        rw_b = 1'b0;
        m_page_b = page_map(d); m_t0_b = cyc; m_idx_b = 0;
    endtask

    task automatic wait_writes_a(input int n);
        int b = 2000;
        while (w_cnt_a < n && b > 0) begin @(negedge clk); #1; b--; end
        if (b == 0) chk("wait_writes_a", 32'(w_cnt_a), 32'(n));
    endtask

    task automatic wait_idle_a(output int waited);
        int b = 3000;
        waited = 0;
        while (act_a && b > 0) begin @(negedge clk); #1; b--; waited++; end
        if (b == 0) chk("wait_idle_a", 32'(act_a), 32'h0);
    endtask

    // Whole OAM image must equal the source page seen through the echo fold.
    task automatic chk_oam_a(input string tag, input logic [7:0] din);
        int bad = 0;
        for (int i = 0; i < 160; i++)
            if (oam_a[i] !== rom({page_map(din), 8'(i)})) bad++;
        chk(tag, 32'(bad), 32'h0);
    endtask

    // Full uninterrupted transfer on instance A with all counters checked.
    task automatic full_xfer_a(input string tag, input logic [7:0] d);
        int w;
        clear_a();
        kick_a(d);
        chk({tag, "_dout"}, 32'(dout_a), 32'(d));
        wait_idle_a(w);
        chk({tag, "_writes"}, 32'(w_cnt_a), 32'd160);
        chk({tag, "_active"}, 32'(act_cnt_a), 32'd644);
        chk({tag, "_model"}, 32'(err_a), 32'h0);
        chk_oam_a({tag, "_oam"}, d);
    endtask

    initial begin
        int w, t_first, t_restart, bad;
        logic [7:0] pg;

        // Reset state
        repeat (3) @(posedge clk);
        #2 n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dout", 32'(dout_a), 32'h00);
        chk("rst_active", 32'(act_a), 32'h0);
        chk("rst_src_adr", 32'(sadr_a), 32'h0000);
        chk("rst_oam_adr", 32'(oadr_a), 32'h00);
        chk("rst_strobes", {30'd0, ow_a, srd_a}, 32'h0);

        // C0 page: OAM gets 5A..C5, 644 active clks, first write ends 8 clks after load
        full_xfer_a("c0", 8'hC0);
        chk("c0_oam_first", 32'(oam_a[0]), 32'h5A);
        chk("c0_oam_last", 32'(oam_a[159]), 32'hC5);

        // Echo page E1 reads from C100..C19F, never E1xx
        full_xfer_a("e1", 8'hE1);
        chk("e1_no_echo_adr", 32'(echo_a), 32'h0);
        chk("e1_last_src_adr", 32'(sadr_a), 32'hC19F);

        // Random pages
        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom_range(0, 255));
            full_xfer_a("rnd", pg);
        end

        // Restart with D0 after 50 bytes: no byte 50 write, full 160 from D000
        clear_a();
        kick_a(8'h47);
        t_first = m_t0_a;
        wait_writes_a(50);
        kick_a(8'hD0);
        t_restart = m_t0_a;
        chk("rs_writes_before", 32'(w_cnt_a), 32'd50);
        wait_idle_a(w);
        chk("rs_writes_total", 32'(w_cnt_a), 32'd210);
        chk("rs_active", 32'(act_cnt_a), 32'(t_restart - t_first + 644));
        chk("rs_model", 32'(err_a), 32'h0);
        chk_oam_a("rs_oam", 8'hD0);

        // Restart on the clk of the index-9F write: write dropped, active never falls
        clear_a();
        kick_a(8'h12);
        repeat (642) @(posedge clk);
        kick_a(8'hC3);
        chk("fin_writes_first", 32'(w_cnt_a), 32'd159);
        chk("fin_active_held", 32'(act_a), 32'h1);
        wait_idle_a(w);
        chk("fin_writes_total", 32'(w_cnt_a), 32'd319);
        chk("fin_active", 32'(act_cnt_a), 32'd1288);
        chk("fin_model", 32'(err_a), 32'h0);
        chk_oam_a("fin_oam", 8'hC3);

        // Reset pulse at byte 100: outputs clear at once, no later writes, dout 00
        clear_a();
        kick_a(8'($urandom_range(8'h00, 8'hDF)));
        wait_writes_a(100);
        @(posedge clk); #2;
        n_reset = 1'b0;
        #1;
        chk("mr_active", 32'(act_a), 32'h0);
        chk("mr_src_adr", 32'(sadr_a), 32'h0000);
        chk("mr_oam_adr", 32'(oadr_a), 32'h00);
        chk("mr_strobes", {30'd0, ow_a, srd_a}, 32'h0);
        chk("mr_dout", 32'(dout_a), 32'h00);
        @(posedge clk); #2;
        n_reset = 1'b1;
        repeat (700) @(posedge clk);
        #2;
        chk("mr_writes_after", 32'(w_cnt_a), 32'd100);
        chk("mr_dout_after", 32'(dout_a), 32'h00);
        chk("mr_idle_after", 32'(act_a), 32'h0);
        chk("mr_model", 32'(err_a), 32'h0);

        // CYCLE_CLKS=2 build, page 80: 322 active clks, 160 correct writes
        w_cnt_b = 0; act_cnt_b = 0; err_b = 0;
        for (int i = 0; i < 160; i++) oam_b[i] = 8'hxx;
        kick_b(8'h80);
        w = 2000;
        while (act_b && w > 0) begin @(negedge clk); #1; w--; end
        chk("cc2_timeout", 32'(w > 0), 32'h1);
        chk("cc2_active", 32'(act_cnt_b), 32'd322);
        chk("cc2_writes", 32'(w_cnt_b), 32'd160);
        chk("cc2_model", 32'(err_b), 32'h0);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (oam_b[i] !== rom({8'h80, 8'(i)})) bad++;
        chk("cc2_oam", 32'(bad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
